// File: rtl/frame_read_scheduler.sv
// Triple-buffer frame scheduler: rotates capture buffers between writer, latest and
// locked roles, then streams the locked frame out of DRAM as credit-gated bursts.
module frame_read_scheduler #(
    parameter int                    ADDR_WIDTH   = 39,
    parameter int                    DATA_WIDTH   = 512,
    parameter logic [ADDR_WIDTH-1:0] FRAME_BASE   = 39'h400000000,
    parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 39'h000400000,
    parameter int                    FRAME_BEATS  = 20480,
    parameter int                    BURST_BEATS  = 64,
    parameter int                    CREDIT_W     = 10
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  frame_wr_done,
    output logic [ADDR_WIDTH-1:0] wr_base_addr,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic [ADDR_WIDTH-1:0] rd_base_addr,
    output logic [15:0]           frame_drop_cnt,
    input  logic [CREDIT_W-1:0]   fifo_free,
    output logic [ADDR_WIDTH-1:0] dram_read_addr,
    output logic [7:0]            dram_read_len,
    output logic                  dram_read_en,
    input  logic                  dram_read_busy,
    input  logic [DATA_WIDTH-1:0] dram_read_data,
    input  logic                  dram_read_data_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    localparam int CNT_W      = $clog2(FRAME_BEATS + 1);
    localparam int MAX_AB     = (CNT_W > CREDIT_W) ? CNT_W : CREDIT_W;
    localparam int CMP_W      = ((MAX_AB > 9) ? MAX_AB : 9) + 1;
    localparam int BEAT_BYTES = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_FRAME = 3'd1;
    localparam logic [2:0] S_ISSUE      = 3'd2;
    localparam logic [2:0] S_WAIT_BURST = 3'd3;
    localparam logic [2:0] S_DRAIN      = 3'd4;

    logic [2:0]       state;
    logic [1:0]       wr_idx;
    logic [1:0]       lat_idx;
    logic [1:0]       lock_idx;
    logic             lat_valid;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] received;
    logic             burst_hold;

    logic             lock_now;
    logic [1:0]       lock_next;
    logic [1:0]       lat_next;
    logic [1:0]       wr_next;
    logic [CMP_W-1:0] beats_left;
    logic [CMP_W-1:0] burst_n;
    logic [CMP_W-1:0] credit_need;
    logic             issue_fire;
    logic             beat_count;

    function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [1:0] idx);
        return FRAME_BASE + ADDR_WIDTH'(idx) * FRAME_STRIDE;
    endfunction

    // The three indices stay a permutation after every done, so the writer's
    // next buffer is simply whichever of {0,1,2} the other two roles leave free.
    always_comb begin
        lock_now  = lat_valid && (((state == S_IDLE) && rd_start) || (state == S_WAIT_FRAME));
        lock_next = lock_now ? lat_idx : lock_idx;
        lat_next  = frame_wr_done ? wr_idx : lat_idx;
        wr_next   = frame_wr_done ? (2'd3 - lat_next - lock_next) : wr_idx;
    end

    always_comb begin
        beats_left  = CMP_W'(FRAME_BEATS) - CMP_W'(issued);
        burst_n     = (beats_left < CMP_W'(BURST_BEATS)) ? beats_left : CMP_W'(BURST_BEATS);
        credit_need = burst_n + CMP_W'(inflight);
        issue_fire  = (state == S_ISSUE) && !dram_read_busy &&
                      (CMP_W'(fifo_free) >= credit_need) &&
                      (issued < CNT_W'(FRAME_BEATS));
        beat_count  = dram_read_data_valid && (state != S_IDLE) && !lock_now;
    end

    assign rd_busy = (state != S_IDLE);

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            wr_idx         <= 2'd0;
            lat_idx        <= 2'd1;
            lock_idx       <= 2'd2;
            lat_valid      <= 1'b0;
            frame_drop_cnt <= 16'd0;
            wr_base_addr   <= FRAME_BASE;
            rd_base_addr   <= '0;
        end else begin
            wr_idx   <= wr_next;
            lat_idx  <= lat_next;
            lock_idx <= lock_next;
            if (frame_wr_done) begin
                lat_valid    <= 1'b1;
                wr_base_addr <= base_of(wr_next);
            end else if (lock_now) begin
                lat_valid <= 1'b0;
            end
            // A done that coincides with a lock replaces nothing unread.
            if (frame_wr_done && lat_valid && !lock_now && (frame_drop_cnt != 16'hFFFF)) begin
                frame_drop_cnt <= frame_drop_cnt + 16'd1;
            end
            if (lock_now) begin
                rd_base_addr <= base_of(lat_idx);
            end
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state          <= S_IDLE;
            burst_hold     <= 1'b0;
            dram_read_en   <= 1'b0;
            dram_read_addr <= '0;
            dram_read_len  <= 8'd0;
            rd_done        <= 1'b0;
        end else begin
            dram_read_en <= 1'b0;
            rd_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_start) begin
                        state <= lat_valid ? S_ISSUE : S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (lat_valid) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_fire) begin
                        dram_read_en   <= 1'b1;
                        dram_read_addr <= rd_base_addr +
                                          ADDR_WIDTH'(issued) * ADDR_WIDTH'(BEAT_BYTES);
                        dram_read_len  <= 8'(burst_n - CMP_W'(1));
                        burst_hold     <= 1'b1;
                        state          <= S_WAIT_BURST;
                    end
                end
                S_WAIT_BURST: begin
                    // One dead cycle gives the controller time to raise its busy flag.
                    if (burst_hold) begin
                        burst_hold <= 1'b0;
                    end else if (!dram_read_busy) begin
                        state <= (issued < CNT_W'(FRAME_BEATS)) ? S_ISSUE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (received == CNT_W'(FRAME_BEATS)) begin
                        rd_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            issued   <= '0;
            inflight <= '0;
            received <= '0;
        end else if (lock_now) begin
            issued   <= '0;
            inflight <= '0;
            received <= '0;
        end else begin
            if (issue_fire) begin
                issued <= issued + CNT_W'(burst_n);
            end
            if (issue_fire && beat_count) begin
                inflight <= inflight + CNT_W'(burst_n) - CNT_W'(1);
            end else if (issue_fire) begin
                inflight <= inflight + CNT_W'(burst_n);
            end else if (beat_count && (inflight != '0)) begin
                inflight <= inflight - CNT_W'(1);
            end
            if (beat_count && (received != CNT_W'(FRAME_BEATS))) begin
                received <= received + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= dram_read_data;
            out_valid <= dram_read_data_valid;
        end
    end

endmodule

// File: tb/tb_frame_read_scheduler.sv
// Randomized bench for frame_read_scheduler with a DRAM responder and a
// role-level model of the three frame buffers and the burst plan.
module tb_frame_read_scheduler;

    localparam int ADDR_WIDTH = 39;
    localparam int DATA_WIDTH = 512;
    localparam logic [38:0] FRAME_BASE   = 39'h400000000;
    localparam logic [38:0] FRAME_STRIDE = 39'h000400000;
    localparam int FB = 100;
    localparam int BB = 64;
    localparam int BEAT_BYTES = 64;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  frame_wr_done;
    logic [38:0]           wr_base_addr;
    logic                  rd_start;
    logic                  rd_busy;
    logic                  rd_done;
    logic [38:0]           rd_base_addr;
    logic [15:0]           frame_drop_cnt;
    logic [9:0]            fifo_free;
    logic [38:0]           dram_read_addr;
    logic [7:0]            dram_read_len;
    logic                  dram_read_en;
    logic                  dram_read_busy;
    logic [DATA_WIDTH-1:0] dram_read_data;
    logic                  dram_read_data_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;

    int total = 0;
    int bad = 0;

    int m_wr, m_lat, m_lock, m_drop;
    bit m_latv;

    logic [38:0]           req_addr_q[$];
    logic [7:0]            req_len_q[$];
    logic [DATA_WIDTH-1:0] sent_q[$];
    logic [DATA_WIDTH-1:0] out_q[$];
    logic [38:0]           exp_addr_q[$];
    int                    exp_len_q[$];
    int beats_pending;
    int busy_left;

    frame_read_scheduler #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .FRAME_BASE(FRAME_BASE), .FRAME_STRIDE(FRAME_STRIDE),
        .FRAME_BEATS(FB), .BURST_BEATS(BB), .CREDIT_W(10)
    ) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .frame_wr_done(frame_wr_done), .wr_base_addr(wr_base_addr),
        .rd_start(rd_start), .rd_busy(rd_busy), .rd_done(rd_done),
        .rd_base_addr(rd_base_addr), .frame_drop_cnt(frame_drop_cnt),
        .fifo_free(fifo_free), .dram_read_addr(dram_read_addr),
        .dram_read_len(dram_read_len), .dram_read_en(dram_read_en),
        .dram_read_busy(dram_read_busy), .dram_read_data(dram_read_data),
        .dram_read_data_valid(dram_read_data_valid),
        .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // DRAM controller stand-in: logs each request, holds busy briefly, returns beats with random gaps.
    initial begin
        dram_read_busy = 1'b0;
        dram_read_data_valid = 1'b0;
        dram_read_data = '0;
        beats_pending = 0;
        busy_left = 0;
        forever begin
            @(negedge clk);
            dram_read_data_valid = 1'b0;
            if (!rst_n) begin
                beats_pending = 0;
                busy_left = 0;
                dram_read_busy = 1'b0;
            end else begin
                if (dram_read_en) begin
                    req_addr_q.push_back(dram_read_addr);
                    req_len_q.push_back(dram_read_len);
                    beats_pending += int'(dram_read_len) + 1;
                    busy_left = $urandom_range(1, 3);
                end
                dram_read_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
                if (beats_pending > 0 && $urandom_range(0, 3) != 0) begin
                    dram_read_data = {16{$urandom()}};
                    dram_read_data_valid = 1'b1;
                    sent_q.push_back(dram_read_data);
                    beats_pending--;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) out_q.push_back(out_data);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [38:0] base_of(input int i);
        return FRAME_BASE + 39'(i) * FRAME_STRIDE;
    endfunction

    function automatic int free_idx(input int a, input int b);
        for (int i = 0; i < 3; i++) if (i != a && i != b) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_wr = 0; m_lat = 1; m_lock = 2; m_latv = 0; m_drop = 0;
    endtask

    task automatic model_done(input bit lock_same);
        if (lock_same) m_lock = m_lat;
        else if (m_latv && m_drop < 65535) m_drop++;
        m_lat = m_wr;
        m_wr = free_idx(m_lat, m_lock);
        m_latv = 1;
    endtask

    task automatic model_lock();
        m_lock = m_lat;
        m_latv = 0;
    endtask

    task automatic build_expected();
        int n;
        exp_addr_q.delete();
        exp_len_q.delete();
        for (int s = 0; s < FB; s += n) begin
            n = (FB - s < BB) ? FB - s : BB;
            exp_addr_q.push_back(base_of(m_lock) + 39'(s * BEAT_BYTES));
            exp_len_q.push_back(n - 1);
        end
    endtask

    task automatic clear_queues();
        req_addr_q.delete(); req_len_q.delete(); sent_q.delete(); out_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_done(input bit with_start);
        frame_wr_done = 1'b1;
        rd_start = with_start;
        model_done(with_start && m_latv);
        tick(1);
        frame_wr_done = 1'b0;
        rd_start = 1'b0;
    endtask

    task automatic start_read();
        rd_start = 1'b1;
        if (m_latv) model_lock();
        tick(1);
        rd_start = 1'b0;
    endtask

    task automatic wait_rd_done(output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick(1);
            if (rd_done) begin
                timed_out = 1'b0;
                break;
            end
        end
        tick(2);
    endtask

    task automatic wait_request(input int want, input int bound, output int cycles);
        cycles = -1;
        for (int c = 1; c <= bound; c++) begin
            tick(1);
            if (req_addr_q.size() >= want) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_wr_done = 1'b0; rd_start = 1'b0; fifo_free = 10'd1023;
        model_reset();
        tick(3);
        total++; if (wr_base_addr !== FRAME_BASE) begin bad++; $display("FAIL reset_wr_base got=%h want=%h", wr_base_addr, FRAME_BASE); end
        total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL reset_rd_busy got=%b want=0", rd_busy); end
        total++; if (rd_done !== 1'b0) begin bad++; $display("FAIL reset_rd_done got=%b want=0", rd_done); end
        total++; if (dram_read_en !== 1'b0) begin bad++; $display("FAIL reset_read_en got=%b want=0", dram_read_en); end
        total++; if (frame_drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", frame_drop_cnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (rd_base_addr !== 39'd0 || dram_read_addr !== 39'd0 || dram_read_len !== 8'd0) begin
            bad++; $display("FAIL reset_addrs got rd=%h dram=%h len=%0d want 0", rd_base_addr, dram_read_addr, dram_read_len); end
        rst_n = 1'b1;
        tick(2);
        total++; if (wr_base_addr !== FRAME_BASE || rd_busy !== 1'b0) begin
            bad++; $display("FAIL post_reset got wr=%h busy=%b want wr=%h busy=0", wr_base_addr, rd_busy, FRAME_BASE); end
    endtask

    task automatic test_basic_read();
        bit to;
        bit data_ok;
        fifo_free = 10'd1023;
        pulse_done(1'b0);
        total++; if (wr_base_addr !== base_of(m_wr)) begin bad++; $display("FAIL basic_wr_base got=%h want=%h", wr_base_addr, base_of(m_wr)); end
        clear_queues();
        start_read();
        build_expected();
        total++; if (rd_busy !== 1'b1 || rd_base_addr !== base_of(m_lock)) begin
            bad++; $display("FAIL basic_lock got busy=%b base=%h want busy=1 base=%h", rd_busy, rd_base_addr, base_of(m_lock)); end
        wait_rd_done(to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got no rd_done want rd_done"); end
        total++; if (req_addr_q.size() != exp_addr_q.size()) begin
            bad++; $display("FAIL basic_bursts got=%0d want=%0d", req_addr_q.size(), exp_addr_q.size()); end
        else for (int i = 0; i < exp_addr_q.size(); i++) begin
            total++; if (req_addr_q[i] !== exp_addr_q[i] || req_len_q[i] !== 8'(exp_len_q[i])) begin
                bad++; $display("FAIL basic_burst%0d got=%h/%0d want=%h/%0d", i, req_addr_q[i], req_len_q[i], exp_addr_q[i], exp_len_q[i]); end
        end
        total++; if (out_q.size() != FB) begin bad++; $display("FAIL basic_beats got=%0d want=%0d", out_q.size(), FB); end
        data_ok = (out_q.size() == sent_q.size());
        for (int i = 0; i < out_q.size() && data_ok; i++) if (out_q[i] !== sent_q[i]) data_ok = 0;
        total++; if (!data_ok) begin bad++; $display("FAIL basic_data got mismatching out_data want copy of dram_read_data"); end
        total++; if (rd_busy !== 1'b0 || rd_done !== 1'b0) begin
            bad++; $display("FAIL basic_idle got busy=%b done=%b want 0/0", rd_busy, rd_done); end
    endtask

    task automatic test_wait_frame();
        bit to;
        int cyc;
        clear_queues();
        start_read();
        tick(10);
        total++; if (req_addr_q.size() != 0 || rd_busy !== 1'b1) begin
            bad++; $display("FAIL wait_idle got reqs=%0d busy=%b want 0/1", req_addr_q.size(), rd_busy); end
        pulse_done(1'b0);
        model_lock();
        build_expected();
        wait_request(1, 2, cyc);
        total++; if (cyc < 0) begin bad++; $display("FAIL wait_latency got none in 2 cycles want burst"); end
        wait_rd_done(to);
        total++; if (to || req_addr_q.size() != 2) begin bad++; $display("FAIL wait_done got to=%b bursts=%0d want 0/2", to, req_addr_q.size()); end
        else begin
            total++; if (req_addr_q[0] !== exp_addr_q[0]) begin bad++; $display("FAIL wait_addr got=%h want=%h", req_addr_q[0], exp_addr_q[0]); end
        end
        total++; if (frame_drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL wait_drop got=%0d want=%0d", frame_drop_cnt, m_drop); end
    endtask

    task automatic test_drops();
        for (int k = 0; k < 3; k++) begin
            pulse_done(1'b0);
            total++; if (wr_base_addr !== base_of(m_wr) || wr_base_addr === base_of(m_lock)) begin
                bad++; $display("FAIL drops_wr_base%0d got=%h want=%h lock=%h", k, wr_base_addr, base_of(m_wr), base_of(m_lock)); end
        end
        total++; if (frame_drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL drops_count got=%0d want=%0d", frame_drop_cnt, m_drop); end
    endtask

    task automatic test_credit();
        bit to;
        int cyc;
        clear_queues();
        fifo_free = 10'd32;
        start_read();
        build_expected();
        tick(20);
        total++; if (req_addr_q.size() != 0 || rd_busy !== 1'b1) begin
            bad++; $display("FAIL credit_block got reqs=%0d busy=%b want 0/1", req_addr_q.size(), rd_busy); end
        fifo_free = 10'd64;
        wait_request(1, 10, cyc);
        total++; if (cyc < 0 || req_len_q[0] !== 8'd63 || req_addr_q[0] !== exp_addr_q[0]) begin
            bad++; $display("FAIL credit_first got cyc=%0d want len 63 at %h", cyc, exp_addr_q[0]); end
        wait_rd_done(to);
        total++; if (to || req_len_q.size() != 2) begin bad++; $display("FAIL credit_done got to=%b bursts=%0d want 0/2", to, req_len_q.size()); end
        else begin
            total++; if (req_len_q[1] !== 8'(exp_len_q[1]) || req_addr_q[1] !== exp_addr_q[1]) begin
                bad++; $display("FAIL credit_short got=%h/%0d want=%h/%0d", req_addr_q[1], req_len_q[1], exp_addr_q[1], exp_len_q[1]); end
        end
        total++; if (out_q.size() != FB) begin bad++; $display("FAIL credit_beats got=%0d want=%0d", out_q.size(), FB); end
        fifo_free = 10'd1023;
    endtask

    task automatic test_same_cycle();
        bit to;
        if (!m_latv) pulse_done(1'b0);
        clear_queues();
        pulse_done(1'b1);
        build_expected();
        total++; if (rd_base_addr !== base_of(m_lock) || wr_base_addr !== base_of(m_wr)) begin
            bad++; $display("FAIL same_bases got rd=%h wr=%h want rd=%h wr=%h", rd_base_addr, wr_base_addr, base_of(m_lock), base_of(m_wr)); end
        total++; if (frame_drop_cnt !== 16'(m_drop) || rd_busy !== 1'b1) begin
            bad++; $display("FAIL same_drop got=%0d busy=%b want=%0d busy=1", frame_drop_cnt, rd_busy, m_drop); end
        wait_rd_done(to);
        total++; if (to || req_addr_q.size() == 0 || req_addr_q[0] !== exp_addr_q[0]) begin
            bad++; $display("FAIL same_read got to=%b bursts=%0d want first at %h", to, req_addr_q.size(), exp_addr_q[0]); end
        clear_queues();
        start_read();
        build_expected();
        wait_rd_done(to);
        total++; if (to || req_addr_q.size() == 0 || req_addr_q[0] !== exp_addr_q[0]) begin
            bad++; $display("FAIL same_reread got to=%b bursts=%0d want first at %h", to, req_addr_q.size(), exp_addr_q[0]); end
    endtask

    task automatic test_random();
        bit to;
        int nd;
        for (int it = 0; it < 5; it++) begin
            nd = $urandom_range(0, 3);
            fifo_free = 10'($urandom_range(64, 1023));
            for (int k = 0; k < nd; k++) pulse_done(1'b0);
            clear_queues();
            if (m_latv) begin
                start_read();
            end else begin
                start_read();
                tick($urandom_range(0, 5));
                pulse_done(1'b0);
                model_lock();
            end
            build_expected();
            wait_rd_done(to);
            total++; if (to || req_addr_q.size() != exp_addr_q.size()) begin
                bad++; $display("FAIL rand%0d_bursts got to=%b n=%0d want n=%0d", it, to, req_addr_q.size(), exp_addr_q.size()); end
            else for (int i = 0; i < exp_addr_q.size(); i++) begin
                total++; if (req_addr_q[i] !== exp_addr_q[i] || req_len_q[i] !== 8'(exp_len_q[i])) begin
                    bad++; $display("FAIL rand%0d_burst%0d got=%h/%0d want=%h/%0d", it, i, req_addr_q[i], req_len_q[i], exp_addr_q[i], exp_len_q[i]); end
            end
            total++; if (out_q.size() != FB || frame_drop_cnt !== 16'(m_drop) || wr_base_addr !== base_of(m_wr)) begin
                bad++; $display("FAIL rand%0d_state got beats=%0d drop=%0d wr=%h want %0d/%0d/%h", it, out_q.size(), frame_drop_cnt, wr_base_addr, FB, m_drop, base_of(m_wr)); end
        end
        fifo_free = 10'd1023;
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        clear_queues();
        pulse_done(1'b0);
        start_read();
        wait_request(1, 10, cyc);
        total++; if (cyc < 0) begin bad++; $display("FAIL midrst_start got no burst want burst"); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (rd_busy !== 1'b0 || dram_read_en !== 1'b0 || rd_done !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl got busy=%b en=%b done=%b ov=%b want 0", rd_busy, dram_read_en, rd_done, out_valid); end
        total++; if (wr_base_addr !== FRAME_BASE || rd_base_addr !== 39'd0 || frame_drop_cnt !== 16'd0 || dram_read_addr !== 39'd0) begin
            bad++; $display("FAIL midrst_regs got wr=%h rd=%h drop=%0d addr=%h want reset values", wr_base_addr, rd_base_addr, frame_drop_cnt, dram_read_addr); end
        model_reset();
        tick(3);
        rst_n = 1'b1;
        tick(3);
        total++; if (rd_busy !== 1'b0 || wr_base_addr !== FRAME_BASE) begin
            bad++; $display("FAIL midrst_after got busy=%b wr=%h want 0/%h", rd_busy, wr_base_addr, FRAME_BASE); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_wait_frame();
        test_drops();
        test_credit();
        test_same_cycle();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
